mfp_ahb_lite_master: RTL and testbench

- AHB-Lite initiator that turns single read/write requests from a local valid/ready port into pipelined SINGLE transfers.
- Drives the same AHB-Lite bus our RAM and SDRAM slaves respond on.
- Address phase of transfer N+1 overlaps the data phase of N.
- Honours slave wait states (HREADY low) and the two-cycle ERROR response.

---
 rtl/mfp_ahb_lite_master_if.sv | 43 ++++
 rtl/mfp_ahb_lite_master.sv | 150 +++++++++++++++
 tb/tb_mfp_ahb_lite_master.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mfp_ahb_lite_master_if.sv
// Bundles the local request/response port and the AHB-Lite bus signals.
// The master modport is the initiator's view; the slave modport is the opposite side.
interface mfp_ahb_lite_master_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [2:0]  req_size;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic [31:0] HADDR;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic [3:0]  HPROT;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    input  req_valid, req_addr, req_write, req_size, req_wdata,
    output req_ready,
    output rsp_valid, rsp_write, rsp_rdata, rsp_err,
    output HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    output req_valid, req_addr, req_write, req_size, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_write, rsp_rdata, rsp_err,
    input  HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWDATA, HWRITE,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/mfp_ahb_lite_master.sv
// AHB-Lite initiator: local single requests become pipelined SINGLE transfers
// through an address-phase (APH) and a data-phase (DPH) register stage.
module mfp_ahb_lite_master #(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input logic                   HCLK,
  input logic                   HRESET,
  mfp_ahb_lite_master_if.master bus
);

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_NONSEQ = 2'b10
  } htrans_t;

  logic        r_aphValid;
  logic [31:0] r_aphAddr;
  logic [2:0]  r_aphSize;
  logic        r_aphWrite;
  logic [31:0] r_aphWdata;

  logic        r_dphValid;
  logic        r_dphWrite;
  logic [31:0] r_dphWdata;

  logic        r_cancel;
  logic        r_misalPend;
  logic        r_misalWrite;

  logic        r_rspValid;
  logic        r_rspWrite;
  logic [31:0] r_rspRdata;
  logic        r_rspErr;

  logic        w_misal;
  logic        w_reqReady;
  logic        w_accept;
  logic        w_advance;
  logic        w_complete;
  logic        w_drained;
  logic        w_errFirst;
  htrans_t     w_htrans;

  assign w_misal = (bus.req_size > 3'd2) ||
                   ((bus.req_size == 3'd1) && bus.req_addr[0]) ||
                   ((bus.req_size == 3'd2) && (bus.req_addr[1:0] != 2'b00));

  assign w_reqReady = !HRESET && !r_cancel && !r_misalPend && (!r_aphValid || bus.HREADY);
  assign w_accept   = bus.req_valid && w_reqReady;
  assign w_advance  = bus.HREADY && r_aphValid && !r_cancel;
  assign w_complete = bus.HREADY && r_dphValid;
  assign w_errFirst = r_dphValid && bus.HRESP && !bus.HREADY;
  // A misaligned request answers only once everything accepted before it has answered.
  assign w_drained  = r_misalPend && !r_aphValid && !r_dphValid;
  assign w_htrans   = (r_aphValid && !r_cancel) ? TRANS_NONSEQ : TRANS_IDLE;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_aphValid <= 1'b0;
      r_aphAddr  <= 32'd0;
      r_aphSize  <= 3'd0;
      r_aphWrite <= 1'b0;
      r_aphWdata <= 32'd0;
    end else if (w_accept && !w_misal) begin
      r_aphValid <= 1'b1;
      r_aphAddr  <= bus.req_addr;
      r_aphSize  <= bus.req_size;
      r_aphWrite <= bus.req_write;
      r_aphWdata <= bus.req_wdata;
    end else if (w_advance) begin
      r_aphValid <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_dphValid <= 1'b0;
      r_dphWrite <= 1'b0;
      r_dphWdata <= 32'd0;
    end else if (w_advance) begin
      r_dphValid <= 1'b1;
      r_dphWrite <= r_aphWrite;
      r_dphWdata <= r_aphWdata;
    end else if (w_complete) begin
      r_dphValid <= 1'b0;
    end
  end

  // Cancel spans the two-cycle ERROR response and keeps APH off the bus meanwhile.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_cancel <= 1'b0;
    end else if (w_complete) begin
      r_cancel <= 1'b0;
    end else if (w_errFirst) begin
      r_cancel <= 1'b1;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_misalPend  <= 1'b0;
      r_misalWrite <= 1'b0;
    end else if (w_accept && w_misal) begin
      r_misalPend  <= 1'b1;
      r_misalWrite <= bus.req_write;
    end else if (w_drained) begin
      r_misalPend  <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_rspValid <= 1'b0;
      r_rspWrite <= 1'b0;
      r_rspRdata <= 32'd0;
      r_rspErr   <= 1'b0;
    end else begin
      r_rspValid <= w_complete || w_drained;
      if (w_complete) begin
        r_rspWrite <= r_dphWrite;
        r_rspErr   <= bus.HRESP;
        r_rspRdata <= (!r_dphWrite && !bus.HRESP) ? bus.HRDATA : 32'd0;
      end else if (w_drained) begin
        r_rspWrite <= r_misalWrite;
        r_rspErr   <= 1'b1;
        r_rspRdata <= 32'd0;
      end else begin
        r_rspErr   <= 1'b0;
        r_rspRdata <= 32'd0;
      end
    end
  end

  assign bus.req_ready = w_reqReady;
  assign bus.rsp_valid = r_rspValid;
  assign bus.rsp_write = r_rspWrite;
  assign bus.rsp_rdata = r_rspRdata;
  assign bus.rsp_err   = r_rspErr;

  assign bus.HADDR     = r_aphAddr;
  assign bus.HSIZE     = r_aphSize;
  assign bus.HWRITE    = r_aphWrite;
  assign bus.HTRANS    = w_htrans;
  assign bus.HWDATA    = r_dphWdata;
  assign bus.HBURST    = 3'b000;
  assign bus.HMASTLOCK = 1'b0;
  assign bus.HPROT     = HPROT_VAL;

endmodule

// File: tb/tb_mfp_ahb_lite_master.sv
// Directed self-checking bench for mfp_ahb_lite_master; the bench plays the AHB slave
// cycle by cycle, drives inputs 1ns after the rising edge and samples on the falling edge.
module tb_mfp_ahb_lite_master;

  logic HCLK;
  logic HRESET;
  int   checkCount;
  int   failCount;

  mfp_ahb_lite_master_if bus();

  mfp_ahb_lite_master #(.HPROT_VAL(4'b0011)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] addr, input logic write,
                               input logic [2:0] size, input logic [31:0] wdata);
    bus.req_valid = valid;
    bus.req_addr  = addr;
    bus.req_write = write;
    bus.req_size  = size;
    bus.req_wdata = wdata;
  endtask

  task automatic setSlave(input logic ready, input logic resp, input logic [31:0] rdata);
    bus.HREADY = ready;
    bus.HRESP  = resp;
    bus.HRDATA = rdata;
  endtask

  task automatic step;
    @(posedge HCLK);
    #1;
  endtask

  task automatic sample;
    @(negedge HCLK);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount = 0;
    failCount  = 0;
    HRESET = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0, 3'd0, 32'd0);
    setSlave(1'b1, 1'b0, 32'd0);

    // Reset state
    sample;
    checkOutput("rst_htrans", 32'(bus.HTRANS), 32'd0);
    checkOutput("rst_haddr", bus.HADDR, 32'd0);
    checkOutput("rst_hwdata", bus.HWDATA, 32'd0);
    checkOutput("rst_hwrite", 32'(bus.HWRITE), 32'd0);
    checkOutput("rst_hsize", 32'(bus.HSIZE), 32'd0);
    checkOutput("rst_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("rst_rspvalid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rst_hprot", 32'(bus.HPROT), 32'd3);
    checkOutput("rst_hburst", 32'(bus.HBURST), 32'd0);
    step;
    HRESET = 1'b0;

    // Single read at 0x100
    applyStimulus(1'b1, 32'h100, 1'b0, 3'd2, 32'd0);
    setSlave(1'b1, 1'b0, 32'hCAFEF00D);
    sample;
    checkOutput("t1_ready", 32'(bus.req_ready), 32'd1);
    step;
    applyStimulus(1'b0, 32'd0, 1'b0, 3'd0, 32'd0);
    sample;
    checkOutput("t1_htrans", 32'(bus.HTRANS), 32'd2);
    checkOutput("t1_haddr", bus.HADDR, 32'h100);
    checkOutput("t1_hwrite", 32'(bus.HWRITE), 32'd0);
    checkOutput("t1_hsize", 32'(bus.HSIZE), 32'd2);
    step;
    sample;
    checkOutput("t1_idle", 32'(bus.HTRANS), 32'd0);
    checkOutput("t1_norsp", 32'(bus.rsp_valid), 32'd0);
    step;
    sample;
    checkOutput("t1_rspvalid", 32'(bus.rsp_valid), 32'd1);
    checkOutput("t1_rdata", bus.rsp_rdata, 32'hCAFEF00D);
    checkOutput("t1_err", 32'(bus.rsp_err), 32'd0);
    checkOutput("t1_rspwrite", 32'(bus.rsp_write), 32'd0);
    step;
    sample;
    checkOutput("t1_rspdone", 32'(bus.rsp_valid), 32'd0);
    step;

    // Three back-to-back writes, zero wait
    applyStimulus(1'b1, 32'h0, 1'b1, 3'd2, 32'd1);
    setSlave(1'b1, 1'b0, 32'd0);
    step;
    applyStimulus(1'b1, 32'h4, 1'b1, 3'd2, 32'd2);
    sample;
    checkOutput("t2_c1_htrans", 32'(bus.HTRANS), 32'd2);
    checkOutput("t2_c1_haddr", bus.HADDR, 32'h0);
    checkOutput("t2_c1_ready", 32'(bus.req_ready), 32'd1);
    step;
    applyStimulus(1'b1, 32'h8, 1'b1, 3'd2, 32'd3);
    sample;
    checkOutput("t2_c2_htrans", 32'(bus.HTRANS), 32'd2);
    checkOutput("t2_c2_haddr", bus.HADDR, 32'h4);
    checkOutput("t2_c2_hwdata", bus.HWDATA, 32'd1);
    step;
    applyStimulus(1'b0, 32'd0, 1'b0, 3'd0, 32'd0);
    sample;
    checkOutput("t2_c3_htrans", 32'(bus.HTRANS), 32'd2);
    checkOutput("t2_c3_haddr", bus.HADDR, 32'h8);
    checkOutput("t2_c3_hwdata", bus.HWDATA, 32'd2);
    checkOutput("t2_c3_rspvalid", 32'(bus.rsp_valid), 32'd1);
    checkOutput("t2_c3_rspwrite", 32'(bus.rsp_write), 32'd1);
    checkOutput("t2_c3_rdata", bus.rsp_rdata, 32'd0);
    step;
    sample;
    checkOutput("t2_c4_htrans", 32'(bus.HTRANS), 32'd0);
    checkOutput("t2_c4_hwdata", bus.HWDATA, 32'd3);
    checkOutput("t2_c4_rspvalid", 32'(bus.rsp_valid), 32'd1);
    step;
    sample;
    checkOutput("t2_c5_rspvalid", 32'(bus.rsp_valid), 32'd1);
    checkOutput("t2_c5_rspwrite", 32'(bus.rsp_write), 32'd1);
    step;
    sample;
    checkOutput("t2_c6_rspvalid", 32'(bus.rsp_valid), 32'd0);
    step;

    // Write then read with two wait states on the write data phase
    applyStimulus(1'b1, 32'h200, 1'b1, 3'd2, 32'hAA);
    step;
    applyStimulus(1'b1, 32'h204, 1'b0, 3'd2, 32'd0);
    step;
    applyStimulus(1'b0, 32'd0, 1'b0, 3'd0, 32'd0);
    setSlave(1'b0, 1'b0, 32'd0);
    sample;
    checkOutput("t3_w1_haddr", bus.HADDR, 32'h204);
    checkOutput("t3_w1_htrans", 32'(bus.HTRANS), 32'd2);
    checkOutput("t3_w1_hwdata", bus.HWDATA, 32'hAA);
    checkOutput("t3_w1_ready", 32'(bus.req_ready), 32'd0);
    step;
    sample;
    checkOutput("t3_w2_haddr", bus.HADDR, 32'h204);
    checkOutput("t3_w2_hwdata", bus.HWDATA, 32'hAA);
    checkOutput("t3_w2_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("t3_w2_norsp", 32'(bus.rsp_valid), 32'd0);
    step;
    setSlave(1'b1, 1'b0, 32'd0);
    sample;
    checkOutput("t3_w3_haddr", bus.HADDR, 32'h204);
    checkOutput("t3_w3_ready", 32'(bus.req_ready), 32'd1);
    step;
    setSlave(1'b1, 1'b0, 32'h12345678);
    sample;
    checkOutput("t3_wr_rspvalid", 32'(bus.rsp_valid), 32'd1);
    checkOutput("t3_wr_rspwrite", 32'(bus.rsp_write), 32'd1);
    checkOutput("t3_wr_err", 32'(bus.rsp_err), 32'd0);
    checkOutput("t3_idle", 32'(bus.HTRANS), 32'd0);
    step;
    sample;
    checkOutput("t3_rd_rspvalid", 32'(bus.rsp_valid), 32'd1);
    checkOutput("t3_rd_rspwrite", 32'(bus.rsp_write), 32'd0);
    checkOutput("t3_rd_rdata", bus.rsp_rdata, 32'h12345678);
    step;

    // ERROR on read 0x40 with write 0x44 waiting in the address phase
    applyStimulus(1'b1, 32'h40, 1'b0, 3'd2, 32'd0);
    setSlave(1'b1, 1'b0, 32'd0);
    step;
    applyStimulus(1'b1, 32'h44, 1'b1, 3'd2, 32'h55);
    sample;
    checkOutput("t4_haddr40", bus.HADDR, 32'h40);
    step;
    applyStimulus(1'b0, 32'd0, 1'b0, 3'd0, 32'd0);
    setSlave(1'b0, 1'b1, 32'd0);
    sample;
    checkOutput("t4_e1_htrans", 32'(bus.HTRANS), 32'd2);
    checkOutput("t4_e1_haddr", bus.HADDR, 32'h44);
    checkOutput("t4_e1_hwrite", 32'(bus.HWRITE), 32'd1);
    step;
    setSlave(1'b1, 1'b1, 32'hDEADBEEF);
    sample;
    checkOutput("t4_e2_htrans", 32'(bus.HTRANS), 32'd0);
    checkOutput("t4_e2_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("t4_e2_norsp", 32'(bus.rsp_valid), 32'd0);
    step;
    setSlave(1'b1, 1'b0, 32'd0);
    sample;
    checkOutput("t4_err_rspvalid", 32'(bus.rsp_valid), 32'd1);
    checkOutput("t4_err_flag", 32'(bus.rsp_err), 32'd1);
    checkOutput("t4_err_rdata", bus.rsp_rdata, 32'd0);
    checkOutput("t4_err_rspwrite", 32'(bus.rsp_write), 32'd0);
    checkOutput("t4_reissue_htrans", 32'(bus.HTRANS), 32'd2);
    checkOutput("t4_reissue_haddr", bus.HADDR, 32'h44);
    step;
    sample;
    checkOutput("t4_wr_hwdata", bus.HWDATA, 32'h55);
    checkOutput("t4_wr_norsp", 32'(bus.rsp_valid), 32'd0);
    step;
    sample;
    checkOutput("t4_wr_rspvalid", 32'(bus.rsp_valid), 32'd1);
    checkOutput("t4_wr_err", 32'(bus.rsp_err), 32'd0);
    checkOutput("t4_wr_rspwrite", 32'(bus.rsp_write), 32'd1);
    step;

    // Misaligned word read at 0x102 behind an in-flight write
    applyStimulus(1'b1, 32'h300, 1'b1, 3'd2, 32'd7);
    step;
    applyStimulus(1'b1, 32'h102, 1'b0, 3'd2, 32'd0);
    sample;
    checkOutput("t5_ready", 32'(bus.req_ready), 32'd1);
    step;
    applyStimulus(1'b0, 32'd0, 1'b0, 3'd0, 32'd0);
    sample;
    checkOutput("t5_nobus", 32'(bus.HTRANS), 32'd0);
    checkOutput("t5_pend_ready", 32'(bus.req_ready), 32'd0);
    step;
    sample;
    checkOutput("t5_wr_rspvalid", 32'(bus.rsp_valid), 32'd1);
    checkOutput("t5_wr_err", 32'(bus.rsp_err), 32'd0);
    checkOutput("t5_wr_rspwrite", 32'(bus.rsp_write), 32'd1);
    checkOutput("t5_nobus2", 32'(bus.HTRANS), 32'd0);
    step;
    sample;
    checkOutput("t5_mis_rspvalid", 32'(bus.rsp_valid), 32'd1);
    checkOutput("t5_mis_err", 32'(bus.rsp_err), 32'd1);
    checkOutput("t5_mis_rdata", bus.rsp_rdata, 32'd0);
    checkOutput("t5_mis_rspwrite", 32'(bus.rsp_write), 32'd0);
    checkOutput("t5_ready_back", 32'(bus.req_ready), 32'd1);
    step;
    sample;
    checkOutput("t5_rspdone", 32'(bus.rsp_valid), 32'd0);
    step;

    // Aligned halfword at 0x102 is legal and goes on the bus
    applyStimulus(1'b1, 32'h102, 1'b0, 3'd1, 32'd0);
    setSlave(1'b1, 1'b0, 32'h0000BEEF);
    step;
    applyStimulus(1'b0, 32'd0, 1'b0, 3'd0, 32'd0);
    sample;
    checkOutput("t5b_htrans", 32'(bus.HTRANS), 32'd2);
    checkOutput("t5b_haddr", bus.HADDR, 32'h102);
    checkOutput("t5b_hsize", 32'(bus.HSIZE), 32'd1);
    step;
    step;
    sample;
    checkOutput("t5b_rspvalid", 32'(bus.rsp_valid), 32'd1);
    checkOutput("t5b_err", 32'(bus.rsp_err), 32'd0);
    checkOutput("t5b_rdata", bus.rsp_rdata, 32'h0000BEEF);
    step;

    // Reset asserted mid data phase during a wait state
    applyStimulus(1'b1, 32'h400, 1'b1, 3'd2, 32'd9);
    setSlave(1'b1, 1'b0, 32'd0);
    step;
    applyStimulus(1'b0, 32'd0, 1'b0, 3'd0, 32'd0);
    sample;
    checkOutput("t6_htrans", 32'(bus.HTRANS), 32'd2);
    step;
    setSlave(1'b0, 1'b0, 32'd0);
    sample;
    checkOutput("t6_hwdata", bus.HWDATA, 32'd9);
    #1;
    HRESET = 1'b1;
    #1;
    checkOutput("t6_async_htrans", 32'(bus.HTRANS), 32'd0);
    checkOutput("t6_async_hwdata", bus.HWDATA, 32'd0);
    checkOutput("t6_async_haddr", bus.HADDR, 32'd0);
    checkOutput("t6_async_hwrite", 32'(bus.HWRITE), 32'd0);
    checkOutput("t6_async_ready", 32'(bus.req_ready), 32'd0);
    step;
    setSlave(1'b1, 1'b0, 32'd0);
    step;
    sample;
    checkOutput("t6_rst_norsp", 32'(bus.rsp_valid), 32'd0);
    step;
    HRESET = 1'b0;
    applyStimulus(1'b1, 32'h500, 1'b0, 3'd2, 32'd0);
    setSlave(1'b1, 1'b0, 32'h600DF00D);
    sample;
    checkOutput("t6_post_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("t6_post_norsp", 32'(bus.rsp_valid), 32'd0);
    step;
    applyStimulus(1'b0, 32'd0, 1'b0, 3'd0, 32'd0);
    sample;
    checkOutput("t6_post_htrans", 32'(bus.HTRANS), 32'd2);
    checkOutput("t6_post_haddr", bus.HADDR, 32'h500);
    step;
    step;
    sample;
    checkOutput("t6_post_rspvalid", 32'(bus.rsp_valid), 32'd1);
    checkOutput("t6_post_rdata", bus.rsp_rdata, 32'h600DF00D);
    step;

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
